// File: rtl/harmonic_switch_ctrl.sv
// Harmonic (1x/2x) select sequencer: applies a requested change at an NCO phase wrap, then holds the lock loop.
// Optional build macro HARM_SW_TIMEOUT_EN adds a forced switch after TIMEOUT_CYC cycles without a wrap.
module harmonic_switch_ctrl #(
  parameter int unsigned PHASE_W     = 16,
  parameter int unsigned SETTLE_W    = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PHASE_W-1:0]  phase_in,
  input  logic                sw_req,
  input  logic                sw_mode,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                freq_double,
  output logic                hold,
  output logic                busy,
  output logic                sw_ack,
  output logic                timeout_flag
);

  typedef enum logic [1:0] {IDLE, WAIT_WRAP, SETTLE} state_t;

  state_t              state, state_nxt;
  logic                prev_msb;
  logic                wrap;
  logic                accept;
  logic                force_sw;
  logic                target, target_nxt;
  logic [SETTLE_W-1:0] cnt, cnt_nxt;
  logic                freq_nxt, hold_nxt, busy_nxt, ack_nxt;

  // Only the MSB matters for wrap detection; the rest of the word is folded away.
  logic unused_phase;
  assign unused_phase = ^phase_in[PHASE_W-2:0];

  assign wrap   = prev_msb & ~phase_in[PHASE_W-1];
  assign accept = (state == IDLE) & sw_req & (sw_mode != freq_double);

`ifdef HARM_SW_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WAIT_W-1:0] wait_cnt;
  logic              tflag;
  logic              wait_done;

  assign wait_done    = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
  assign force_sw     = wait_done;
  assign timeout_flag = tflag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      tflag    <= 1'b0;
    end else if (accept) begin
      wait_cnt <= '0;
      tflag    <= 1'b0;
    end else if (state == WAIT_WRAP) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
      // A real wrap in the timeout cycle wins and leaves the flag clear.
      if (!wrap && wait_done) tflag <= 1'b1;
    end
  end
`else
  assign force_sw     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_msb    <= 1'b0;
      target      <= 1'b0;
      cnt         <= '0;
      freq_double <= 1'b0;
      hold        <= 1'b0;
      busy        <= 1'b0;
      sw_ack      <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_msb    <= phase_in[PHASE_W-1];
      target      <= target_nxt;
      cnt         <= cnt_nxt;
      freq_double <= freq_nxt;
      hold        <= hold_nxt;
      busy        <= busy_nxt;
      sw_ack      <= ack_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = cnt;
    freq_nxt   = freq_double;
    hold_nxt   = hold;
    busy_nxt   = busy;
    ack_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sw_req) begin
          if (sw_mode == freq_double) begin
            ack_nxt = 1'b1;
          end else begin
            // Settle length is captured here and is immune to later register writes.
            target_nxt = sw_mode;
            cnt_nxt    = settle_cycles;
            busy_nxt   = 1'b1;
            state_nxt  = WAIT_WRAP;
          end
        end
      end
      WAIT_WRAP: begin
        if (wrap || force_sw) begin
          freq_nxt  = target;
          hold_nxt  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - SETTLE_W'(1);
        end else begin
          hold_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_harmonic_switch_ctrl.sv
// Self-checking bench for harmonic_switch_ctrl: a scoreboard of expected completions is compared on each sw_ack.
// Build with HARM_SW_TIMEOUT_EN defined to exercise the forced-switch path.
module tb_harmonic_switch_ctrl;

  localparam int PHASE_W  = 16;
  localparam int SETTLE_W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [PHASE_W-1:0]  phase_in = '0;
  logic                sw_req = 1'b0;
  logic                sw_mode = 1'b0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic                freq_double, hold, busy, sw_ack, timeout_flag;

  logic ramp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   hold_run = 0;

  typedef struct {
    logic freq;
    int   hold_len;
  } exp_t;

  exp_t exp_q[$];

  harmonic_switch_ctrl #(
    .PHASE_W    (PHASE_W),
    .SETTLE_W   (SETTLE_W),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase_in     (phase_in),
    .sw_req       (sw_req),
    .sw_mode      (sw_mode),
    .settle_cycles(settle_cycles),
    .freq_double  (freq_double),
    .hold         (hold),
    .busy         (busy),
    .sw_ack       (sw_ack),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // NCO model: +0x0100 per clock when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ramp_en) phase_in = phase_in + 16'h0100;
    end
  end

  // Completion monitor: each sw_ack pops one expectation and checks the final select and hold length.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_run = 0;
      end else begin
        if (hold === 1'b1) hold_run++;
        if (sw_ack === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: sw_ack=1 with no outstanding request at %0t", $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (freq_double !== e.freq || hold_run != e.hold_len || hold !== 1'b0 || busy !== 1'b0) begin
              errors++;
              $display("FAIL ack_result: freq_double=%b hold_cycles=%0d hold=%b busy=%b, expected freq_double=%b hold_cycles=%0d hold=0 busy=0",
                       freq_double, hold_run, hold, busy, e.freq, e.hold_len);
            end
          end
          hold_run = 0;
        end
      end
    end
  end

  task automatic drive_req(input logic mode, input logic [SETTLE_W-1:0] settle);
    @(posedge clk);
    #1;
    sw_req        = 1'b1;
    sw_mode       = mode;
    settle_cycles = settle;
    @(posedge clk);
    #1;
    sw_req = 1'b0;
  endtask

  task automatic wait_ack(input int bound, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sw_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no sw_ack within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_hold(input int bound, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (hold === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: hold never rose within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({freq_double, hold, busy, sw_ack, timeout_flag} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: {freq,hold,busy,ack,tflag}=%b expected 00000",
               {freq_double, hold, busy, sw_ack, timeout_flag});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_switch_up();
    bit wrapped = 1'b0;
    ramp_en = 1'b1;
    exp_q.push_back('{freq: 1'b1, hold_len: 5});
    drive_req(1'b1, 16'd4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hold !== 1'b0) begin
      errors++;
      $display("FAIL accept_busy: busy=%b hold=%b expected busy=1 hold=0", busy, hold);
    end
    for (int i = 0; i < 300; i++) begin
      if (phase_in == 16'h0000) begin
        wrapped = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!wrapped || freq_double !== 1'b0) begin
      errors++;
      $display("FAIL pre_wrap: wrapped=%b freq_double=%b expected wrap seen and freq_double=0", wrapped, freq_double);
    end
    @(negedge clk);
    checks++;
    if (freq_double !== 1'b1 || hold !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_wrap: freq=%b hold=%b busy=%b expected 1 1 1", freq_double, hold, busy);
    end
    wait_ack(20, "switch_up_ack");
    @(negedge clk);
    checks++;
    if (sw_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse: sw_ack=%b busy=%b expected 0 0 after one-cycle ack", sw_ack, busy);
    end
  endtask

  task automatic test_noop();
    exp_q.push_back('{freq: 1'b1, hold_len: 0});
    drive_req(1'b1, 16'd7);
    @(negedge clk);
    checks++;
    if (sw_ack !== 1'b1 || busy !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL noop: sw_ack=%b busy=%b hold=%b expected 1 0 0", sw_ack, busy, hold);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hold !== 1'b0 || freq_double !== 1'b1) begin
      errors++;
      $display("FAIL noop_after: busy=%b hold=%b freq=%b expected 0 0 1", busy, hold, freq_double);
    end
  endtask

  task automatic test_ignore_during_settle();
    int extra = 0;
    exp_q.push_back('{freq: 1'b0, hold_len: 7});
    drive_req(1'b0, 16'd6);
    settle_cycles = 16'd0;
    wait_hold(300, "ignore_hold");
    @(posedge clk);
    #1;
    sw_req = 1'b1;
    sw_mode = 1'b1;
    settle_cycles = 16'd3;
    @(posedge clk);
    #1;
    sw_req = 1'b0;
    wait_ack(20, "ignore_ack");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sw_ack === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (freq_double !== 1'b0 || extra != 0) begin
      errors++;
      $display("FAIL ignore_in_settle: freq=%b extra_activity=%0d expected freq=0 extra=0", freq_double, extra);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{freq: 1'b1, hold_len: 2});
    drive_req(1'b1, 16'd1);
    wait_hold(300, "b2b_hold");
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back('{freq: 1'b0, hold_len: 1});
    sw_req = 1'b1;
    sw_mode = 1'b0;
    settle_cycles = 16'd0;
    @(negedge clk);
    checks++;
    if (sw_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack_cycle: sw_ack=%b expected 1 while second request is presented", sw_ack);
    end
    @(posedge clk);
    #1;
    sw_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    wait_ack(300, "b2b_second_ack");
  endtask

  task automatic test_reset_in_settle();
    drive_req(1'b1, 16'd10);
    wait_hold(300, "rst_hold");
    checks++;
    if (freq_double !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: freq=%b hold=%b expected 1 1", freq_double, hold);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({freq_double, hold, busy, sw_ack, timeout_flag} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: {freq,hold,busy,ack,tflag}=%b expected 00000 before any clock edge",
               {freq_double, hold, busy, sw_ack, timeout_flag});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.push_back('{freq: 1'b1, hold_len: 1});
    drive_req(1'b1, 16'd0);
    wait_ack(300, "post_reset_ack");
  endtask

  task automatic test_timeout();
    int wait_cycles = 0;
    ramp_en = 1'b0;
    rst_n = 1'b0;
    phase_in = 16'h1234;
    @(negedge clk);
    #2 rst_n = 1'b1;
`ifdef HARM_SW_TIMEOUT_EN
    exp_q.push_back('{freq: 1'b1, hold_len: 1});
`endif
    drive_req(1'b1, 16'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (freq_double === 1'b1) break;
      wait_cycles++;
    end
`ifdef HARM_SW_TIMEOUT_EN
    checks++;
    if (wait_cycles != 10 || timeout_flag !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL timeout_force: wait=%0d tflag=%b hold=%b expected 10 1 1", wait_cycles, timeout_flag, hold);
    end
    wait_ack(5, "timeout_ack");
    exp_q.push_back('{freq: 1'b0, hold_len: 1});
    drive_req(1'b0, 16'd0);
    @(negedge clk);
    checks++;
    if (timeout_flag !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: tflag=%b busy=%b expected 0 1", timeout_flag, busy);
    end
    wait_ack(40, "timeout_second_ack");
`else
    checks++;
    if (wait_cycles != 40 || busy !== 1'b1 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: wait=%0d busy=%b tflag=%b expected 40 1 0", wait_cycles, busy, timeout_flag);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_switch_up();
    test_noop();
    test_ignore_during_settle();
    test_back_to_back();
    test_reset_in_settle();
    test_timeout();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected completions never acknowledged", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
